// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong capture buffer controller: steers ADC words into the filling bank and
// hands completed banks to the DMA reader via request/grant/done.
module pingpong_bank_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int OVF_W  = 16
) (
  input  logic              trn_clk,
  input  logic              trn_reset_n,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_we,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic              rd_bank,
  input  logic              rd_done,
  output logic [1:0]        bank_full,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_t;

  bank_state_t       st [2];
  logic              sel;
  logic [ADDR_W-1:0] ptr;
  logic              last_full;

  logic can_write, accept, drop, last_word;
  logic full0, full1, any_drain, grant, grant_bank;

  always_comb begin
    can_write  = (st[sel] == EMPTY) || (st[sel] == FILL);
    accept     = enable & wr_valid & can_write;
    drop       = enable & wr_valid & ~can_write;
    last_word  = (ptr == ADDR_W'(DEPTH - 1));
    full0      = (st[0] == FULL);
    full1      = (st[1] == FULL);
    any_drain  = (st[0] == DRAIN) || (st[1] == DRAIN);
    grant      = rd_req & ~any_drain & (full0 | full1);
    // Both full: the older bank is the one that did not fill most recently.
    grant_bank = (full0 & full1) ? ~last_full : full1;
    bank_full  = {full1, full0};
    busy       = (st[0] != EMPTY) || (st[1] != EMPTY);
  end

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      st[0]     <= EMPTY;
      st[1]     <= EMPTY;
      sel       <= 1'b0;
      ptr       <= '0;
      last_full <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      wr_we     <= '0;
      rd_grant  <= 1'b0;
      rd_bank   <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      // Outputs trail the pointer by one cycle so wr_addr names the word just accepted.
      wr_bank  <= sel;
      wr_addr  <= ptr;
      wr_we    <= accept ? '1 : '0;
      rd_grant <= grant;

      if (accept) begin
        ptr <= ptr + 1'b1;
        if (last_word) begin
          sel       <= ~sel;
          last_full <= sel;
        end
      end

      if (drop && (ovf_cnt != '1))
        ovf_cnt <= ovf_cnt + 1'b1;

      if (grant)
        rd_bank <= grant_bank;

      // Write-side and read-side transitions act on disjoint states, so they never collide.
      for (int unsigned i = 0; i < 2; i++) begin
        if (accept && (sel == 1'(i)))
          st[i] <= last_word ? FULL : FILL;
        else if (grant && (grant_bank == 1'(i)))
          st[i] <= DRAIN;
        else if (rd_done && (st[i] == DRAIN) && (rd_bank == 1'(i)))
          st[i] <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl with ADDR_W=4/DEPTH=16; a second
// instance with a 3-bit overflow counter shares the stimulus.
module tb_pingpong_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_done = 1'b0;

  logic       wr_bank, rd_grant, rd_bank, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_we;
  logic [1:0] bank_full;
  logic [15:0] ovf_cnt;

  logic       s_wr_bank, s_rd_grant, s_rd_bank, s_busy;
  logic [3:0] s_wr_addr;
  logic [7:0] s_wr_we;
  logic [1:0] s_bank_full;
  logic [2:0] s_ovf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pingpong_bank_ctrl #(.ADDR_W(4), .DEPTH(16), .OVF_W(16)) dut (
    .trn_clk(clk), .trn_reset_n(rst_n), .enable(enable), .wr_valid(wr_valid),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_we(wr_we),
    .rd_req(rd_req), .rd_grant(rd_grant), .rd_bank(rd_bank), .rd_done(rd_done),
    .bank_full(bank_full), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  pingpong_bank_ctrl #(.ADDR_W(4), .DEPTH(16), .OVF_W(3)) dut_sat (
    .trn_clk(clk), .trn_reset_n(rst_n), .enable(enable), .wr_valid(wr_valid),
    .wr_bank(s_wr_bank), .wr_addr(s_wr_addr), .wr_we(s_wr_we),
    .rd_req(rd_req), .rd_grant(s_rd_grant), .rd_bank(s_rd_bank), .rd_done(rd_done),
    .bank_full(s_bank_full), .ovf_cnt(s_ovf_cnt), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic write_n(input int n);
    enable = 1'b1; wr_valid = 1'b1;
    repeat (n) cyc();
    wr_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_we"}, 32'(wr_we), 0);
    chk({tag, "_rd_grant"}, 32'(rd_grant), 0);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 0);
    chk({tag, "_bank_full"}, 32'(bank_full), 0);
    chk({tag, "_ovf"}, 32'(ovf_cnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk_all_zero("rst");
    rst_n = 1'b1;

    // Disabled strobes are ignored and not counted
    enable = 1'b0; wr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("dis_we", 32'(wr_we), 0);
    end
    wr_valid = 1'b0;
    chk("dis_ovf", 32'(ovf_cnt), 0);
    chk("dis_busy", 32'(busy), 0);

    // Fill bank 0
    enable = 1'b1; wr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("fill_we", 32'(wr_we), 32'hFF);
      chk("fill_addr", 32'(wr_addr), 32'(k));
      chk("fill_bank", 32'(wr_bank), 0);
    end
    wr_valid = 1'b0;
    cyc();
    chk("fill_done_we", 32'(wr_we), 0);
    chk("fill_done_bank", 32'(wr_bank), 1);
    chk("fill_done_addr", 32'(wr_addr), 0);
    chk("fill_done_full", 32'(bank_full), 32'b01);
    chk("fill_done_busy", 32'(busy), 1);

    // Drain bank 0
    rd_req = 1'b1;
    cyc();
    chk("grant_pulse", 32'(rd_grant), 1);
    chk("grant_bank", 32'(rd_bank), 0);
    chk("grant_full", 32'(bank_full), 0);
    cyc();
    chk("grant_once", 32'(rd_grant), 0);
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    chk("done_full", 32'(bank_full), 0);
    chk("done_busy", 32'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("no_regrant", 32'(rd_grant), 0);
    end
    rd_req = 1'b0;

    // Overflow and oldest-first ordering
    do_reset();
    write_n(32);
    cyc();
    chk("ovf_full", 32'(bank_full), 32'b11);
    chk("ovf_wr_bank", 32'(wr_bank), 0);
    enable = 1'b1; wr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("drop_we", 32'(wr_we), 0);
    end
    wr_valid = 1'b0;
    chk("ovf_cnt5", 32'(ovf_cnt), 5);
    chk("ovf_sat5", 32'(s_ovf_cnt), 5);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    chk("ovf_grant", 32'(rd_grant), 1);
    chk("ovf_grant_bank", 32'(rd_bank), 0);
    chk("ovf_grant_full", 32'(bank_full), 32'b10);
    rd_done = 1'b1; wr_valid = 1'b1;
    cyc();
    rd_done = 1'b0;
    chk("done_drop_we", 32'(wr_we), 0);
    chk("done_drop_ovf", 32'(ovf_cnt), 6);
    cyc();
    wr_valid = 1'b0;
    chk("resume_we", 32'(wr_we), 32'hFF);
    chk("resume_addr", 32'(wr_addr), 0);
    chk("resume_bank", 32'(wr_bank), 0);
    chk("resume_ovf", 32'(ovf_cnt), 6);

    // Saturation of the 3-bit counter
    do_reset();
    write_n(32);
    write_n(10);
    cyc();
    chk("sat_wide", 32'(ovf_cnt), 10);
    chk("sat_narrow", 32'(s_ovf_cnt), 7);

    // Asynchronous reset mid-fill with a grant pending
    do_reset();
    write_n(23);
    chk("pre_async_addr", 32'(wr_addr), 6);
    chk("pre_async_bank", 32'(wr_bank), 1);
    wr_valid = 1'b1; rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    #2;
    rst_n = 1'b1;
    cyc();
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("post_async_we", 32'(wr_we), 32'hFF);
    chk("post_async_addr", 32'(wr_addr), 0);
    chk("post_async_bank", 32'(wr_bank), 0);
    chk("post_async_grant", 32'(rd_grant), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
